// File: rtl/cache_line_fetcher_if.sv
// Bundles the request/response streams and the AXI4 read channels of the line fetcher.
interface cache_line_fetcher_if #(
  parameter int unsigned TAGS_WIDTH     = 48,
  parameter int unsigned ADDR_WIDTH     = 64,
  parameter int unsigned DATA_PORT_SIZE = 512
);
  logic                      req_tvalid;
  logic                      req_tready;
  logic [TAGS_WIDTH-1:0]     req_tdata;

  logic                      rsp_tvalid;
  logic                      rsp_tready;
  logic [DATA_PORT_SIZE-1:0] rsp_tdata;
  logic                      rsp_tlast;

  logic [ADDR_WIDTH-1:0]     m_axi_araddr;
  logic [7:0]                m_axi_arlen;
  logic [2:0]                m_axi_arsize;
  logic [1:0]                m_axi_arburst;
  logic                      m_axi_arvalid;
  logic                      m_axi_arready;

  logic [DATA_PORT_SIZE-1:0] m_axi_rdata;
  logic [1:0]                m_axi_rresp;
  logic                      m_axi_rlast;
  logic                      m_axi_rvalid;
  logic                      m_axi_rready;

  modport master (
    input  req_tvalid, req_tdata,
    output req_tready,
    output rsp_tvalid, rsp_tdata, rsp_tlast,
    input  rsp_tready,
    output m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
    input  m_axi_arready,
    input  m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    output m_axi_rready
  );

  modport slave (
    output req_tvalid, req_tdata,
    input  req_tready,
    input  rsp_tvalid, rsp_tdata, rsp_tlast,
    output rsp_tready,
    input  m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
    output m_axi_arready,
    output m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    input  m_axi_rready
  );
endinterface

// File: rtl/cache_line_fetcher.sv
// Cache miss refill: one tag in, one AXI4 INCR read burst out, line returned beat by beat.
module cache_line_fetcher #(
  parameter int unsigned TAGS_WIDTH     = 48,
  parameter int unsigned ADDR_WIDTH     = 64,
  parameter int unsigned CACHE_SIZE     = 512,
  parameter int unsigned DATA_PORT_SIZE = 512,
  parameter logic [63:0] BASE_ADDR      = 64'h0
) (
  input  logic                 clk,
  input  logic                 rstn,
  cache_line_fetcher_if.master bus,
  output logic [1:0]           err_status,
  input  logic                 err_clear,
  output logic [31:0]          fetch_count,
  output logic                 busy
);
  localparam int unsigned BEATS      = CACHE_SIZE / DATA_PORT_SIZE;
  localparam int unsigned LINE_SHIFT = $clog2(CACHE_SIZE / 8);
  localparam logic [2:0]  AXI_SIZE   = 3'($clog2(DATA_PORT_SIZE / 8));
  localparam logic [8:0]  BEATS_W    = 9'(BEATS);
  localparam logic [8:0]  LAST_BEAT  = 9'(BEATS - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_AR   = 2'd1;
  localparam logic [1:0] ST_R    = 2'd2;

  logic [1:0]            state;
  logic [8:0]            beat_cnt;
  logic [TAGS_WIDTH-1:0] tag;
  logic [ADDR_WIDTH-1:0] line_addr;
  logic                  req_hs;
  logic                  r_hs;
  logic                  fwd;
  logic [1:0]            err_next;

  assign tag       = bus.req_tdata;
  assign line_addr = ADDR_WIDTH'(BASE_ADDR) + (ADDR_WIDTH'(tag) << LINE_SHIFT);

  // Gated by rstn so the request port stays closed while reset is held.
  assign bus.req_tready   = rstn && (state == ST_IDLE);
  assign bus.m_axi_arvalid = (state == ST_AR);
  assign bus.m_axi_arlen   = 8'(BEATS - 1);
  assign bus.m_axi_arsize  = AXI_SIZE;
  assign bus.m_axi_arburst = 2'b01;
  // Surplus beats past the line end are drained regardless of the response side.
  assign bus.m_axi_rready  = (state == ST_R) &&
                             ((beat_cnt == BEATS_W) || !bus.rsp_tvalid || bus.rsp_tready);
  assign busy = (state != ST_IDLE);

  assign req_hs = bus.req_tvalid && bus.req_tready;
  assign r_hs   = bus.m_axi_rvalid && bus.m_axi_rready;
  assign fwd    = r_hs && (beat_cnt < BEATS_W);

  always_comb begin
    err_next = err_clear ? 2'b00 : err_status;
    if (r_hs && (bus.m_axi_rresp != 2'b00))
      err_next[0] = 1'b1;
    if (r_hs && (!(beat_cnt < BEATS_W) || (bus.m_axi_rlast && (beat_cnt != LAST_BEAT))))
      err_next[1] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state            <= ST_IDLE;
      beat_cnt         <= '0;
      bus.m_axi_araddr <= '0;
      err_status       <= '0;
      fetch_count      <= '0;
    end else begin
      err_status <= err_next;
      case (state)
        ST_IDLE: begin
          if (req_hs) begin
            bus.m_axi_araddr <= line_addr;
            state            <= ST_AR;
          end
        end
        ST_AR: begin
          if (bus.m_axi_arready) begin
            beat_cnt <= '0;
            state    <= ST_R;
          end
        end
        ST_R: begin
          if (fwd)
            beat_cnt <= beat_cnt + 9'd1;
          if (r_hs && bus.m_axi_rlast) begin
            fetch_count <= fetch_count + 32'd1;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Output holding register runs independently so a final beat can wait while IDLE accepts.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      bus.rsp_tvalid <= 1'b0;
      bus.rsp_tdata  <= '0;
      bus.rsp_tlast  <= 1'b0;
    end else if (fwd) begin
      bus.rsp_tvalid <= 1'b1;
      bus.rsp_tdata  <= bus.m_axi_rdata;
      bus.rsp_tlast  <= (beat_cnt == LAST_BEAT);
    end else if (bus.rsp_tvalid && bus.rsp_tready) begin
      bus.rsp_tvalid <= 1'b0;
      bus.rsp_tlast  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_cache_line_fetcher.sv
// Bench for cache_line_fetcher: a 4-beat-line instance driven against a scoreboard and a 1-beat instance for latency.
module tb_cache_line_fetcher;
  localparam int unsigned DW = 512;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn;
  int   checks = 0;
  int   errors = 0;

  cache_line_fetcher_if #(.TAGS_WIDTH(48), .ADDR_WIDTH(64), .DATA_PORT_SIZE(DW)) a_if ();
  cache_line_fetcher_if #(.TAGS_WIDTH(48), .ADDR_WIDTH(64), .DATA_PORT_SIZE(DW)) b_if ();

  logic [1:0]  a_err, b_err;
  logic        a_clr, b_clr;
  logic [31:0] a_fc, b_fc;
  logic        a_busy, b_busy;

  cache_line_fetcher #(
    .TAGS_WIDTH(48), .ADDR_WIDTH(64), .CACHE_SIZE(2048),
    .DATA_PORT_SIZE(DW), .BASE_ADDR(64'h1000_0000)
  ) u_a (
    .clk(clk), .rstn(rstn), .bus(a_if),
    .err_status(a_err), .err_clear(a_clr), .fetch_count(a_fc), .busy(a_busy)
  );

  cache_line_fetcher #(
    .TAGS_WIDTH(48), .ADDR_WIDTH(64), .CACHE_SIZE(512),
    .DATA_PORT_SIZE(DW), .BASE_ADDR(64'h0)
  ) u_b (
    .clk(clk), .rstn(rstn), .bus(b_if),
    .err_status(b_err), .err_clear(b_clr), .fetch_count(b_fc), .busy(b_busy)
  );

  beat_t       sb[$];
  logic [1:0]  exp_err_a = 2'b00;
  logic [31:0] exp_fc_a  = 32'd0;

  task automatic check(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_beat();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic idle_a();
    a_if.req_tvalid = 1'b0; a_if.req_tdata = '0; a_if.rsp_tready = 1'b1;
    a_if.m_axi_arready = 1'b0; a_if.m_axi_rvalid = 1'b0; a_if.m_axi_rdata = '0;
    a_if.m_axi_rresp = 2'b00; a_if.m_axi_rlast = 1'b0; a_clr = 1'b0;
  endtask

  task automatic idle_b();
    b_if.req_tvalid = 1'b0; b_if.req_tdata = '0; b_if.rsp_tready = 1'b1;
    b_if.m_axi_arready = 1'b0; b_if.m_axi_rvalid = 1'b0; b_if.m_axi_rdata = '0;
    b_if.m_axi_rresp = 2'b00; b_if.m_axi_rlast = 1'b0; b_clr = 1'b0;
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, "_rsp_tvalid"}, a_if.rsp_tvalid, 0);
    check({tag, "_rsp_tdata"}, a_if.rsp_tdata, 0);
    check({tag, "_rsp_tlast"}, a_if.rsp_tlast, 0);
    check({tag, "_arvalid"}, a_if.m_axi_arvalid, 0);
    check({tag, "_araddr"}, a_if.m_axi_araddr, 0);
    check({tag, "_rready"}, a_if.m_axi_rready, 0);
    check({tag, "_err"}, a_err, 0);
    check({tag, "_fc"}, a_fc, 0);
    check({tag, "_busy"}, a_busy, 0);
    check({tag, "_req_tready"}, a_if.req_tready, 0);
  endtask

  // One fetch on the 4-beat instance; negative knobs disable that feature.
  task automatic run_a(input logic [47:0] tag, input int nbeats, input int err_beat,
                       input int clr_beat, input int stall_beat, input int rst_after);
    int            idx = 0, popped = 0, drain = 0, stall_left = 4;
    bit            req_done = 0, ar_done = 0, r_done = 0, finished = 0, did_rst = 0, clr;
    logic [DW-1:0] cur;
    cur = rand_beat();
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clk);
      if (rst_after >= 0 && ar_done && idx == rst_after) begin
        idle_a();
        rstn = 1'b0;
        @(negedge clk);
        #1;
        check_reset_a("midrst");
        rstn = 1'b1;
        sb.delete();
        exp_err_a = 2'b00;
        exp_fc_a  = 32'd0;
        did_rst   = 1;
        break;
      end
      a_if.req_tvalid    = !req_done;
      a_if.req_tdata     = tag;
      a_if.m_axi_arready = 1'b1;
      a_if.m_axi_rvalid  = ar_done && !r_done && (idx < nbeats);
      a_if.m_axi_rdata   = cur;
      a_if.m_axi_rlast   = (idx == nbeats - 1);
      a_if.m_axi_rresp   = (idx == err_beat) ? 2'b10 : 2'b00;
      a_if.rsp_tready    = 1'b1;
      if (stall_beat >= 0 && popped == stall_beat && a_if.rsp_tvalid && stall_left > 0) begin
        a_if.rsp_tready = 1'b0;
        stall_left--;
      end
      clr   = a_if.m_axi_rvalid && (idx == clr_beat);
      a_clr = clr;
      #1;
      if (a_if.rsp_tvalid) begin
        if (sb.size() == 0) check("rsp_spurious", 1, 0);
        else begin
          check("rsp_data", a_if.rsp_tdata, sb[0].data);
          check("rsp_last", a_if.rsp_tlast, sb[0].last);
          if (a_if.rsp_tready) begin
            void'(sb.pop_front());
            popped++;
          end
        end
      end
      if (ar_done && !r_done && idx < 4 && a_if.rsp_tvalid && !a_if.rsp_tready)
        check("rready_stall", a_if.m_axi_rready, 0);
      if (ar_done && !r_done && idx >= 4 && a_if.m_axi_rvalid)
        check("rready_drop", a_if.m_axi_rready, 1);
      if (!req_done && a_if.req_tready) req_done = 1;
      if (!ar_done && a_if.m_axi_arvalid) begin
        check("araddr", a_if.m_axi_araddr, 64'h1000_0000 + (64'(tag) << 8));
        check("arlen", a_if.m_axi_arlen, 3);
        check("arsize", a_if.m_axi_arsize, 6);
        check("arburst", a_if.m_axi_arburst, 1);
        ar_done = 1;
      end
      if (clr) exp_err_a = 2'b00;
      if (a_if.m_axi_rvalid && a_if.m_axi_rready) begin
        if (idx < 4) sb.push_back('{data: cur, last: (idx == 3)});
        if (a_if.m_axi_rresp != 2'b00) exp_err_a[0] = 1'b1;
        if (idx >= 4 || (a_if.m_axi_rlast && idx != 3)) exp_err_a[1] = 1'b1;
        if (a_if.m_axi_rlast) begin
          r_done = 1;
          exp_fc_a++;
        end
        idx++;
        cur = rand_beat();
      end
      if (r_done && sb.size() == 0) drain++;
      if (drain >= 2) begin
        finished = 1;
        break;
      end
    end
    if (!did_rst) begin
      if (!finished) check("a_timeout", 0, 1);
      @(negedge clk);
      idle_a();
      #1;
      check("a_busy_end", a_busy, 0);
      check("a_req_tready_end", a_if.req_tready, 1);
      check("a_err_end", a_err, exp_err_a);
      check("a_fc_end", a_fc, exp_fc_a);
      check("a_sb_empty", sb.size(), 0);
    end
  endtask

  task automatic pulse_clear_a();
    @(negedge clk);
    a_clr = 1'b1;
    @(negedge clk);
    a_clr = 1'b0;
    exp_err_a = 2'b00;
    #1;
    check("a_err_cleared", a_err, 0);
  endtask

  logic [DW-1:0] bd;

  initial begin
    rstn = 1'b0;
    idle_a();
    idle_b();
    repeat (3) @(negedge clk);
    #1;
    check_reset_a("rst");
    check("b_rst_rsp_tvalid", b_if.rsp_tvalid, 0);
    check("b_rst_busy", b_busy, 0);
    check("b_rst_req_tready", b_if.req_tready, 0);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    check("a_req_tready_after_rst", a_if.req_tready, 1);

    // Single-beat latency on the default-sized instance
    @(negedge clk);
    b_if.req_tvalid = 1'b1; b_if.req_tdata = 48'h5; b_if.m_axi_arready = 1'b1;
    #1;
    check("b_req_tready", b_if.req_tready, 1);
    check("b_arvalid_n", b_if.m_axi_arvalid, 0);
    @(negedge clk);
    b_if.req_tvalid = 1'b0;
    #1;
    check("b_arvalid_n1", b_if.m_axi_arvalid, 1);
    check("b_araddr", b_if.m_axi_araddr, 64'h140);
    check("b_arlen", b_if.m_axi_arlen, 0);
    check("b_arsize", b_if.m_axi_arsize, 6);
    check("b_arburst", b_if.m_axi_arburst, 1);
    @(negedge clk);
    bd = rand_beat();
    b_if.m_axi_rvalid = 1'b1; b_if.m_axi_rdata = bd; b_if.m_axi_rlast = 1'b1;
    #1;
    check("b_rready_n2", b_if.m_axi_rready, 1);
    check("b_rsp_tvalid_n2", b_if.rsp_tvalid, 0);
    @(negedge clk);
    b_if.m_axi_rvalid = 1'b0; b_if.m_axi_rlast = 1'b0;
    #1;
    check("b_rsp_tvalid_n3", b_if.rsp_tvalid, 1);
    check("b_rsp_tlast_n3", b_if.rsp_tlast, 1);
    check("b_rsp_tdata_n3", b_if.rsp_tdata, bd);
    check("b_busy_n3", b_busy, 0);
    check("b_fc", b_fc, 1);
    check("b_err", b_err, 0);
    @(negedge clk);
    #1;
    check("b_rsp_consumed", b_if.rsp_tvalid, 0);

    run_a(48'h3, 4, -1, -1, -1, -1);   // plain 4-beat line
    run_a(48'h7, 4, -1, -1, 1, -1);    // response back-pressure on beat 1
    run_a(48'h9, 4, 2, -1, -1, -1);    // SLVERR on beat 2
    run_a(48'hA, 4, 0, 0, -1, -1);     // clear collides with new SLVERR
    pulse_clear_a();
    run_a(48'hB, 2, -1, -1, -1, -1);   // early rlast
    pulse_clear_a();
    run_a(48'hC, 5, -1, -1, -1, -1);   // one surplus beat
    pulse_clear_a();
    run_a(48'hD, 4, -1, -1, -1, 1);    // reset mid-burst
    run_a(48'h0, 4, -1, -1, -1, -1);   // line 0 after reset

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cache_line_fetcher.md
# cache_line_fetcher

Miss-refill engine directly downstream of the LRU cache way's backend port. Accepts a single line tag on a request stream, issues one AXI4 INCR read burst for the whole cache line, and returns the line as DATA_PORT_SIZE-wide beats on a response stream. It sits between the cache way and the 250 MHz box memory/AXI interconnect. One fetch is outstanding at a time.

## Interface
- TAGS_WIDTH, 48, line tag width; must match the cache way.
- ADDR_WIDTH, 64, AXI address width.
- CACHE_SIZE, 512, line size in bits; must be an integer multiple of DATA_PORT_SIZE.
- DATA_PORT_SIZE, 512, response beat width and AXI data width; power of two, ≥ 8.
- BASE_ADDR, 64'h0, byte address of line 0.
- Derived: BEATS = CACHE_SIZE/DATA_PORT_SIZE, with 1 ≤ BEATS ≤ 256.
- clk  in  1  clock.
- rstn  in  1  synchronous active-low reset.
- req_tvalid / req_tready  in / out  1 / 1  request handshake.
- req_tdata  in  TAGS_WIDTH  line tag to fetch.
- rsp_tvalid / rsp_tready  out / in  1 / 1  response handshake; the cache way ties rsp_tready high, but the block honours it.
- rsp_tdata  out  DATA_PORT_SIZE  line beat.
- rsp_tlast  out  1  set on beat BEATS-1.
- m_axi_araddr  out  ADDR_WIDTH  burst address.
- m_axi_arlen  out  8  equals BEATS-1.
- m_axi_arsize  out  3  log2(DATA_PORT_SIZE/8).
- m_axi_arburst  out  2  constant 2'b01 (INCR).
- m_axi_arvalid / m_axi_arready  out / in  1 / 1  AR handshake.
- m_axi_rdata  in  DATA_PORT_SIZE  read data.
- m_axi_rresp  in  2  read response.
- m_axi_rlast / m_axi_rvalid  in  1 / 1  R channel.
- m_axi_rready  out  1  R channel ready.
- err_status  out  2  sticky error flags: [0] rresp≠OKAY, [1] burst length mismatch.
- err_clear  in  1  clears err_status.
- fetch_count  out  32  number of completed bursts; wraps modulo 2^32.
- busy  out  1  state ≠ IDLE.

## Operation
- FSM states: IDLE, AR, R.
  - IDLE: req_tready=1. On a req handshake, latch the tag, compute araddr = BASE_ADDR + (tag << log2(CACHE_SIZE/8)) truncated to ADDR_WIDTH, and go to AR.
  - AR: m_axi_arvalid=1 with araddr, arlen, arsize and arburst held stable. On arready, go to R and clear the beat counter.
  - R: m_axi_rready = !rsp_tvalid || rsp_tready.
- Each R handshake while beat counter < BEATS: load the output register (rsp_tdata=rdata, rsp_tlast = counter==BEATS-1, rsp_tvalid=1), then increment the counter.
- Any R handshake with rresp≠2'b00 sets err_status[0]. The beat is still forwarded.
- Beats arriving after the counter reaches BEATS: m_axi_rready is forced to 1, the beats are dropped (not forwarded), and err_status[1] is set.
- The R state ends only on an R handshake with rlast=1. At that point:
  - err_status[1] is set if the counter (before increment) ≠ BEATS-1 (early rlast);
  - fetch_count increments;
  - the FSM returns to IDLE.
- Early-rlast case: the missing beats are never emitted, and rsp_tlast is never asserted for that burst.
- Output register: single stage, independent of the FSM. It clears on rsp handshake unless it is reloaded in the same cycle.
- err_clear: clears err_status in the cycle it is asserted. If a set event occurs in the same cycle, the set wins.

## Timing
- Reset values:
  - FSM = IDLE; req_tready=0 during reset, 1 in the first cycle after reset.
  - rsp_tvalid=0, rsp_tdata=0, rsp_tlast=0.
  - m_axi_arvalid=0, m_axi_araddr=0, m_axi_rready=0.
  - err_status=0, fetch_count=0, busy=0.
- Request handshake in cycle N: m_axi_arvalid=1 from cycle N+1.
- AR handshake in cycle M: m_axi_rready may go high from cycle M+1.
- R handshake in cycle K: rsp_tvalid=1 in cycle K+1.
- Minimum latency is 3 cycles from the request handshake to the first rsp_tvalid, assuming zero-wait arready/rvalid.
- Back-to-back rate: one beat per cycle with rsp_tready=1. With rsp_tready=0, at most one beat is held and rready drops.
- The next request can be accepted in the cycle after the final rlast handshake, even while the last beat is still unconsumed in the output register.
- rstn low mid-burst: all state returns to reset values on the next edge. The AXI burst is abandoned; the system resets both sides together.

## Test plan
- BASE_ADDR=0x1000_0000, CACHE_SIZE=2048, tag=0x3 -> araddr=0x1000_0300, arlen=3, arsize=6, arburst=1; 4 beats D0..D3 emitted in order, tlast only on D3, fetch_count=1.
- Defaults (BEATS=1), tag=0x5, zero-wait slave -> arvalid at N+1, rsp_tvalid with tlast=1 at N+3, busy low by N+3.
- CACHE_SIZE=2048, rsp_tready held low after beat 1 -> rready drops, beat 1 held stable, no beat lost or duplicated when rsp_tready returns.
- Beat 2 returns rresp=2'b10 -> data still forwarded, err_status=2'b01; err_clear pulsed in the same cycle as a new SLVERR beat -> err_status stays 01.
- CACHE_SIZE=2048, slave asserts rlast on beat 1 -> err_status[1]=1, FSM returns to IDLE, rsp_tlast never asserted; slave sends 5 beats -> beat 5 dropped, err_status[1]=1.
- rstn asserted during the R state after beat 1 -> all outputs return to reset values next cycle; a new request of tag=0x0 fetches araddr=BASE_ADDR correctly.
